// File: rtl/frame_scanout_pkg.sv
// Shared video constants and scan-out fetch FSM encoding; the frame drawer
// imports the same geometry so both sides agree on the framebuffer layout.
package frame_scanout_pkg;

    localparam int H_RES     = 640;
    localparam int V_RES     = 480;
    localparam int BPP_BYTES = 4;
    localparam int X_W       = 10;
    localparam int PIX_W     = 24;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        NEXT
    } fetch_state_t;

    // Byte address of pixel (x, y) in framebuffer disp, wrapping modulo 2^32.
    function automatic logic [31:0] pixel_addr(input logic [31:0] base,
                                               input logic        disp,
                                               input logic [9:0]  y,
                                               input logic [9:0]  x);
        logic [31:0] idx;
        idx = 32'(x) + 32'(H_RES) * (32'(y) + 32'(V_RES) * 32'(disp));
        return base + 32'(BPP_BYTES) * idx;
    endfunction

endpackage

// File: rtl/frame_scanout_linebuf.sv
// Ping-pong line buffer: one write port, one registered read port, address {bank, x}.
module frame_scanout_linebuf #(
    parameter int DATA_W = 24,
    parameter int ADDR_W = 11
) (
    input  logic              clock,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/frame_scanout.sv
// Display-side framebuffer reader: prefetches the next line from SDRAM into a
// ping-pong line buffer and serves RGB to the video stage.
module frame_scanout
    import frame_scanout_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] in_framebuffer_base,
    input  logic        in_fbuffer,
    input  logic        in_vsync,
    input  logic [9:0]  in_pix_x,
    input  logic [9:0]  in_pix_y,
    input  logic        in_pix_active,
    input  logic [31:0] in_sd_data_out,
    input  logic        in_sd_done,
    output logic [31:0] out_sd_addr,
    output logic        out_sd_rw,
    output logic [31:0] out_sd_data_in,
    output logic        out_sd_in_valid,
    output logic [3:0]  out_sd_wmask,
    output logic [7:0]  out_pix_r,
    output logic [7:0]  out_pix_g,
    output logic [7:0]  out_pix_b,
    output logic        out_underrun
);

    localparam logic [9:0] X_LAST = 10'(H_RES - 1);
    localparam logic [9:0] Y_LAST = 10'(V_RES - 1);

    fetch_state_t     state;
    logic [9:0]       fx, fy;
    logic             disp_buf;
    logic [1:0]       line_ready;
    logic             vsync_d;
    logic [9:0]       pix_y_d;
    logic             pend_vld, pend_vs;
    logic [9:0]       pend_y;

    logic             trig_vs, trig_ln, ln_acc;
    logic [9:0]       trig_y;
    logic             nx_vld, nx_vs;
    logic [9:0]       nx_y;
    logic [1:0]       ready_clr;
    logic             disp_nx, start_go;

    logic             lb_we;
    logic [X_W:0]     lb_waddr, lb_raddr;
    logic [PIX_W-1:0] pix_p1;
    logic             vld_p1, rdy_p1;
    logic             unused_sd_pad;

    assign out_sd_rw      = 1'b0;
    assign out_sd_data_in = '0;
    assign out_sd_wmask   = 4'b0000;
    assign unused_sd_pad  = ^in_sd_data_out[31:24];

    // A pending vsync fetch of line 0 is never displaced by a later line trigger.
    always_comb begin
        trig_vs   = in_vsync & ~vsync_d;
        trig_ln   = (in_pix_y != pix_y_d) && (in_pix_y < Y_LAST);
        trig_y    = in_pix_y + 10'd1;
        ln_acc    = trig_ln && !trig_vs && !(pend_vld && pend_vs);
        nx_vld    = pend_vld;
        nx_vs     = pend_vs;
        nx_y      = pend_y;
        ready_clr = 2'b00;
        if (trig_vs) begin
            nx_vld    = 1'b1;
            nx_vs     = 1'b1;
            nx_y      = 10'd0;
            ready_clr = 2'b11;
        end else if (ln_acc) begin
            nx_vld    = 1'b1;
            nx_vs     = 1'b0;
            nx_y      = trig_y;
            ready_clr = trig_y[0] ? 2'b10 : 2'b01;
        end
        disp_nx  = trig_vs ? in_fbuffer : disp_buf;
        start_go = nx_vld && (in_framebuffer_base != '0) &&
                   ((state == IDLE) || (state == NEXT));
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            fx              <= '0;
            fy              <= '0;
            disp_buf        <= 1'b0;
            line_ready      <= '0;
            vsync_d         <= 1'b0;
            pix_y_d         <= '0;
            pend_vld        <= 1'b0;
            pend_vs         <= 1'b0;
            pend_y          <= '0;
            out_sd_addr     <= '0;
            out_sd_in_valid <= 1'b0;
        end else begin
            vsync_d         <= in_vsync;
            pix_y_d         <= in_pix_y;
            pend_vld        <= nx_vld;
            pend_vs         <= nx_vs;
            pend_y          <= nx_y;
            disp_buf        <= disp_nx;
            line_ready      <= line_ready & ~ready_clr;
            out_sd_in_valid <= 1'b0;
            if (start_go) begin
                pend_vld             <= 1'b0;
                pend_vs              <= 1'b0;
                fy                   <= nx_y;
                fx                   <= '0;
                line_ready[nx_y[0]]  <= 1'b0;
                out_sd_addr          <= pixel_addr(in_framebuffer_base, disp_nx, nx_y, 10'd0);
                out_sd_in_valid      <= 1'b1;
                state                <= ISSUE;
            end else begin
                case (state)
                    IDLE:  state <= IDLE;
                    ISSUE: state <= WAIT;
                    WAIT:  if (in_sd_done) state <= NEXT;
                    NEXT: begin
                        // A trigger seen here abandons the current line.
                        if (nx_vld) begin
                            state <= IDLE;
                        end else if (fx == X_LAST) begin
                            line_ready[fy[0]] <= 1'b1;
                            state             <= IDLE;
                        end else begin
                            fx              <= fx + 10'd1;
                            out_sd_addr     <= pixel_addr(in_framebuffer_base, disp_buf, fy, fx + 10'd1);
                            out_sd_in_valid <= 1'b1;
                            state           <= ISSUE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign lb_we    = (state == WAIT) && in_sd_done;
    assign lb_waddr = {fy[0], fx};
    assign lb_raddr = {in_pix_y[0], in_pix_x};

    frame_scanout_linebuf #(
        .DATA_W (PIX_W),
        .ADDR_W (X_W + 1)
    ) u_linebuf (
        .clock   (clock),
        .wr_en   (lb_we),
        .wr_addr (lb_waddr),
        .wr_data (in_sd_data_out[PIX_W-1:0]),
        .rd_addr (lb_raddr),
        .rd_data (pix_p1)
    );

    // Pixel stage p0 -> p1: qualifiers travel with the registered RAM read.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vld_p1       <= 1'b0;
            rdy_p1       <= 1'b0;
            out_underrun <= 1'b0;
        end else begin
            vld_p1 <= in_pix_active;
            rdy_p1 <= line_ready[in_pix_y[0]];
            if (in_pix_active && !line_ready[in_pix_y[0]]) begin
                out_underrun <= 1'b1;
            end
        end
    end

    assign out_pix_r = (vld_p1 && rdy_p1) ? pix_p1[23:16] : 8'd0;
    assign out_pix_g = (vld_p1 && rdy_p1) ? pix_p1[15:8]  : 8'd0;
    assign out_pix_b = (vld_p1 && rdy_p1) ? pix_p1[7:0]   : 8'd0;

endmodule
